logic_slice_unit: RTL



---
 rtl/logic_slice_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/logic_slice_unit.sv
// Sliced bitwise logic unit: applies one of eight ops to two W-bit operands, S bits per clock.
// Optional LOGIC_SLICE_FLAGS_EN adds parity and neg result flags.
module logic_slice_unit #(
    parameter int unsigned W = 64,
    parameter int unsigned S = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] in_0,
    input  logic [W-1:0] in_1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         zero
`ifdef LOGIC_SLICE_FLAGS_EN
    ,
    output logic         parity,
    output logic         neg
`endif
);

    localparam int unsigned N  = W / S;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  result_q, result_d;
    logic          nz_q, nz_d;
    logic [S-1:0]  sl_a, sl_b, sl_res;
`ifdef LOGIC_SLICE_FLAGS_EN
    logic          par_q, par_d;
`endif

    // Only the slice addressed by the counter reaches the S-bit gate array.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                sl_a = a_q[k*S +: S];
                sl_b = b_q[k*S +: S];
            end
        end
    end

    always_comb begin
        sl_res = '0;
        unique case (op_q)
            3'b000: sl_res = sl_a & sl_b;
            3'b001: sl_res = sl_a | sl_b;
            3'b010: sl_res = sl_a ^ sl_b;
            3'b011: sl_res = ~(sl_a | sl_b);
            3'b100: sl_res = ~(sl_a & sl_b);
            3'b101: sl_res = ~(sl_a ^ sl_b);
            3'b110: sl_res = ~sl_a;
            3'b111: sl_res = sl_a;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        nz_d     = nz_q;
`ifdef LOGIC_SLICE_FLAGS_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_0;
                    b_d      = in_1;
                    op_d     = op;
                    cnt_d    = '0;
                    result_d = '0;
                    nz_d     = 1'b0;
`ifdef LOGIC_SLICE_FLAGS_EN
                    par_d    = 1'b0;
`endif
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) begin
                        result_d[k*S +: S] = sl_res;
                    end
                end
                nz_d = nz_q | (|sl_res);
`ifdef LOGIC_SLICE_FLAGS_EN
                par_d = par_q ^ (^sl_res);
`endif
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            nz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            nz_q     <= nz_d;
        end
    end

`ifdef LOGIC_SLICE_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity = out_valid & par_q;
    assign neg    = out_valid & result_q[W-1];
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    // Flags are only meaningful alongside out_valid, so they read 0 elsewhere.
    assign zero      = out_valid & ~nz_q;

endmodule
